// File: rtl/tcdm_stream_pkg.sv
// tcdm_stream_pkg: shared types and constants for the TCDM stream reader.
//   state_e        reader FSM states
//   TCDM_BE_ALL    byte enable for full-word accesses
//   TCDM_WEN_READ  wen level that marks a read
//   WORD_BYTES     address increment per 32-bit word
package tcdm_stream_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [3:0]  TCDM_BE_ALL   = 4'hF;
  localparam logic        TCDM_WEN_READ = 1'b1;
  localparam int unsigned WORD_BYTES    = 4;

endpackage

// File: rtl/tcdm_stream_fifo.sv
// tcdm_stream_fifo: DEPTH x 32-bit synchronous FIFO holding read responses.
//   clk_i, rst_i   clock, async active-high reset
//   push_i, data_i write side
//   pop_i, data_o  read side; data_o shows the head entry
//   full_o, empty_o, count_o  occupancy
// Push while full is accepted only together with a pop.
module tcdm_stream_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         push_i,
  input  logic [31:0]                  data_i,
  input  logic                         pop_i,
  output logic [31:0]                  data_o,
  output logic                         full_o,
  output logic                         empty_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [31:0]      mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             push_s;
  logic             pop_s;

  assign full_o  = (count_r == CNT_W'(DEPTH));
  assign empty_o = (count_r == CNT_W'(0));
  assign count_o = count_r;
  assign data_o  = mem_r[rd_ptr_r];
  assign pop_s   = pop_i && !empty_o;
  assign push_s  = push_i && (!full_o || pop_s);

  // Storage, pointers and occupancy
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_r[i] <= 32'h0000_0000;
      end
      wr_ptr_r <= PTR_W'(0);
      rd_ptr_r <= PTR_W'(0);
      count_r  <= CNT_W'(0);
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= data_i;
        wr_ptr_r <= (wr_ptr_r == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= (rd_ptr_r == PTR_W'(DEPTH - 1)) ? PTR_W'(0) : rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_r + CNT_W'(push_s) - CNT_W'(pop_s);
    end
  end

endmodule

// File: rtl/tcdm_stream_reader_chk.sv
// tcdm_stream_reader_chk: simulation-only protocol checks for the reader.
//   r_valid_i      response valid from the TCDM responder
//   outstanding_i  granted-but-unanswered request count
//   push_i, pop_i, full_i  response FIFO activity
module tcdm_stream_reader_chk #(
  parameter int unsigned CNT_W = 3
) (
  input logic             clk_i,
  input logic             rst_i,
  input logic             r_valid_i,
  input logic [CNT_W-1:0] outstanding_i,
  input logic             push_i,
  input logic             pop_i,
  input logic             full_i
);

  // A response with nothing outstanding means responder and reader disagree.
  a_resp_expected: assert property (@(posedge clk_i) disable iff (rst_i)
    r_valid_i |-> (outstanding_i != CNT_W'(0)))
    else $error("tcdm_stream_reader: r_valid with no outstanding request");

  // Credits must keep the response FIFO from overflowing.
  a_no_overflow: assert property (@(posedge clk_i) disable iff (rst_i)
    (push_i && full_i) |-> pop_i)
    else $error("tcdm_stream_reader: response FIFO overflow");

endmodule

// File: rtl/tcdm_stream_reader.sv
// tcdm_stream_reader: reads len_i consecutive 32-bit words from TCDM starting
// at addr_i and streams them out in order on data_o/valid_o/ready_i.
//   clk_i, rst_i           clock, async active-high reset
//   start_i/addr_i/len_i   transfer command (sampled in IDLE only)
//   busy_o, done_o         status; done_o pulses once per transfer
//   tcdm_*                 TCDM initiator port (reads only)
//   data_o/valid_o/ready_i output stream
// Optional macro TCDM_STREAM_READER_STATS_EN adds stall_cnt_o and resp_cnt_o.
module tcdm_stream_reader
  import tcdm_stream_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned LEN_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              tcdm_req_o,
  input  logic              tcdm_gnt_i,
  output logic [ADDR_W-1:0] tcdm_add_o,
  output logic              tcdm_wen_o,
  output logic [3:0]        tcdm_be_o,
  output logic [31:0]       tcdm_data_o,
  input  logic [31:0]       tcdm_r_data_i,
  input  logic              tcdm_r_valid_i,
  output logic [31:0]       data_o,
  output logic              valid_o,
`ifdef TCDM_STREAM_READER_STATS_EN
  output logic [31:0]       stall_cnt_o,
  output logic [31:0]       resp_cnt_o,
`endif
  input  logic              ready_i
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  state_e            state_r, state_s;
  logic [ADDR_W-1:0] addr_r;
  logic [LEN_W-1:0]  issue_cnt_r;
  logic [LEN_W-1:0]  pop_cnt_r;
  logic [CNT_W-1:0]  out_cnt_r;
  logic              req_r;
  logic              done_r;

  logic              gnt_s, push_s, pop_s, start_go_s, last_pop_s;
  logic              fifo_empty_s, fifo_full_s;
  logic [CNT_W-1:0]  fifo_count_s, out_next_s, fifo_next_s;
  logic [SUM_W-1:0]  credit_sum_s;
  logic              req_next_s;

  assign gnt_s      = req_r && tcdm_gnt_i;
  // Responses arriving with nothing outstanding are dropped.
  assign push_s     = tcdm_r_valid_i && (out_cnt_r != CNT_W'(0));
  assign pop_s      = valid_o && ready_i;
  assign start_go_s = (state_r == IDLE) && start_i && (len_i != LEN_W'(0));
  assign last_pop_s = pop_s && (pop_cnt_r == LEN_W'(1));

  assign busy_o      = (state_r != IDLE);
  assign done_o      = done_r;
  assign tcdm_req_o  = req_r;
  assign tcdm_add_o  = addr_r;
  assign tcdm_wen_o  = TCDM_WEN_READ;
  assign tcdm_be_o   = TCDM_BE_ALL;
  assign tcdm_data_o = 32'h0000_0000;
  assign valid_o     = !fifo_empty_s;

  tcdm_stream_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_s),
    .data_i  (tcdm_r_data_i),
    .pop_i   (pop_s),
    .data_o  (data_o),
    .full_o  (fifo_full_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_count_s)
  );

  tcdm_stream_reader_chk #(.CNT_W(CNT_W)) u_chk (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .r_valid_i     (tcdm_r_valid_i),
    .outstanding_i (out_cnt_r),
    .push_i        (push_s),
    .pop_i         (pop_s),
    .full_i        (fifo_full_s)
  );

  // FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE:    if (start_go_s) state_s = ISSUE; else state_s = IDLE;
      ISSUE:   if (gnt_s && (issue_cnt_r == LEN_W'(1))) state_s = DRAIN; else state_s = ISSUE;
      DRAIN:   if (last_pop_s) state_s = IDLE; else state_s = DRAIN;
      default: state_s = IDLE;
    endcase
  end

  // Credit look-ahead for the registered request. Outstanding+buffered only
  // grows on a grant, so a raised request keeps its credit until granted.
  always_comb begin
    out_next_s   = out_cnt_r + CNT_W'(gnt_s) - CNT_W'(push_s);
    fifo_next_s  = fifo_count_s + CNT_W'(push_s) - CNT_W'(pop_s);
    credit_sum_s = SUM_W'(out_next_s) + SUM_W'(fifo_next_s);
    req_next_s   = (state_s == ISSUE) && (credit_sum_s < SUM_W'(FIFO_DEPTH));
  end

  // Address, length and outstanding counters plus request/done registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      addr_r      <= ADDR_W'(0);
      issue_cnt_r <= LEN_W'(0);
      pop_cnt_r   <= LEN_W'(0);
      out_cnt_r   <= CNT_W'(0);
      req_r       <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      req_r     <= req_next_s;
      out_cnt_r <= out_next_s;
      done_r    <= ((state_r == IDLE) && start_i && (len_i == LEN_W'(0))) ||
                   ((state_r == DRAIN) && last_pop_s);
      if (start_go_s) begin
        addr_r      <= addr_i;
        issue_cnt_r <= len_i;
        pop_cnt_r   <= len_i;
      end else begin
        if (gnt_s) begin
          addr_r      <= addr_r + ADDR_W'(WORD_BYTES);
          issue_cnt_r <= issue_cnt_r - LEN_W'(1);
        end
        if (pop_s) begin
          pop_cnt_r <= pop_cnt_r - LEN_W'(1);
        end
      end
    end
  end

`ifdef TCDM_STREAM_READER_STATS_EN
  logic [31:0] stall_cnt_r;
  logic [31:0] resp_cnt_r;

  assign stall_cnt_o = stall_cnt_r;
  assign resp_cnt_o  = resp_cnt_r;

  // Saturating stall and response counters, cleared when IDLE takes a start
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_r <= 32'h0000_0000;
      resp_cnt_r  <= 32'h0000_0000;
    end else if ((state_r == IDLE) && start_i) begin
      stall_cnt_r <= 32'h0000_0000;
      resp_cnt_r  <= 32'h0000_0000;
    end else begin
      if (req_r && !tcdm_gnt_i && (stall_cnt_r != 32'hFFFF_FFFF)) begin
        stall_cnt_r <= stall_cnt_r + 32'h0000_0001;
      end
      if (tcdm_r_valid_i && (resp_cnt_r != 32'hFFFF_FFFF)) begin
        resp_cnt_r <= resp_cnt_r + 32'h0000_0001;
      end
    end
  end
`else
  // Statistics counters are not built in this configuration.
`endif

endmodule
